// File: rtl/ad9361_spi_pkg.sv
// Shared types and widths for the AD9361 SPI command arbiter.
package ad9361_spi_pkg;

   localparam int unsigned AD_ADDR_W = 10;
   localparam int unsigned AD_DATA_W = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } arb_state_e;

   // Index width that stays legal for a single requester.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ad9361_spi_arbiter_if.sv
// Command/completion bus between the arbiter and the AD9361 SPI master.
interface ad9361_spi_arbiter_if;
   import ad9361_spi_pkg::*;

   logic                 wr_req;
   logic [AD_ADDR_W-1:0] wr_addr;
   logic [AD_DATA_W-1:0] wr_data;
   logic                 rd_req;
   logic [AD_ADDR_W-1:0] rd_addr;
   logic                 wr_end;
   logic                 rd_end;
   logic [AD_DATA_W-1:0] rd_data;

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr,
      input  wr_end, rd_end, rd_data
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
      output wr_end, rd_end, rd_data
   );

endinterface

// File: rtl/ad9361_rr_pick.sv
// Combinational grant selector: requester 0 absolute under prio_lock, else round-robin after rr.
module ad9361_rr_pick #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr,
   input  logic               prio_lock,
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);

   always_comb begin
      logic        found;
      logic [31:0] pos;
      grant = '0;
      found = 1'b0;
      pos   = '0;
      valid = |req;
      if (prio_lock && req[0]) begin
         grant[0] = 1'b1;
      end else begin
         // Search starts just past the last served requester and wraps.
         for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = (32'(rr) + k) % NUM_REQ;
            if (!found && req[pos[IDX_W-1:0]]) begin
               grant[pos[IDX_W-1:0]] = 1'b1;
               found                 = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ad9361_spi_arbiter.sv
// Serialises commands from NUM_REQ requesters onto one AD9361 SPI master and
// returns completion, read data or a timeout error to the owning requester.
module ad9361_spi_arbiter
   import ad9361_spi_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned TMR_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          prio_lock,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*AD_ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*AD_DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          req_err,
   output logic [AD_DATA_W-1:0]          rd_data,
   output logic                          busy,
   output logic                          stray_end,
   input  logic                          stray_clr,
   ad9361_spi_arbiter_if.master          spi
);

   localparam int unsigned IdxW = idx_w(NUM_REQ);
   localparam logic [TMR_W-1:0] TmoLast = (TIMEOUT_CYC == 0) ? '0 : TMR_W'(TIMEOUT_CYC - 1);

   arb_state_e           state_q, state_d;
   logic [IdxW-1:0]      rr_q, rr_d;
   logic [IdxW-1:0]      gnt_idx_q, gnt_idx_d, pick_idx;
   logic [NUM_REQ-1:0]   pick_grant;
   logic                 pick_valid;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 lat_wr_q, lat_wr_d;
   logic [AD_ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [AD_DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic                 wr_end_q, rd_end_q;
   logic [AD_DATA_W-1:0] rd_smp_q;
   logic                 end_hit, tmo_hit, stray_ev;
   logic [NUM_REQ-1:0]   ack_q, ack_d, done_q, done_d;
   logic                 err_q, err_d, busy_q, busy_d, stray_q, stray_d;
   logic                 spi_wr_req_q, spi_wr_req_d, spi_rd_req_q, spi_rd_req_d;
   logic [AD_DATA_W-1:0] rd_data_q, rd_data_d;

   ad9361_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IdxW)
   ) u_pick (
      .req       (req),
      .rr        (rr_q),
      .prio_lock (prio_lock),
      .grant     (pick_grant),
      .valid     (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_grant[i]) pick_idx = IdxW'(i);
      end
   end

   // End pulses are judged one cycle late, against the registered copy.
   assign end_hit  = (state_q == StWait) && (lat_wr_q ? wr_end_q : rd_end_q);
   assign tmo_hit  = (TIMEOUT_CYC != 0) && (timer_q == TmoLast);
   assign stray_ev = (state_q != StWait) ? (wr_end_q | rd_end_q)
                                         : (lat_wr_q ? rd_end_q : wr_end_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         rr_q         <= IdxW'(NUM_REQ - 1);
         gnt_idx_q    <= '0;
         timer_q      <= '0;
         lat_wr_q     <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         wr_end_q     <= 1'b0;
         rd_end_q     <= 1'b0;
         rd_smp_q     <= '0;
         ack_q        <= '0;
         done_q       <= '0;
         err_q        <= 1'b0;
         rd_data_q    <= '0;
         busy_q       <= 1'b0;
         stray_q      <= 1'b0;
         spi_wr_req_q <= 1'b0;
         spi_rd_req_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         gnt_idx_q    <= gnt_idx_d;
         timer_q      <= timer_d;
         lat_wr_q     <= lat_wr_d;
         lat_addr_q   <= lat_addr_d;
         lat_wdata_q  <= lat_wdata_d;
         wr_end_q     <= spi.wr_end;
         rd_end_q     <= spi.rd_end;
         rd_smp_q     <= spi.rd_data;
         ack_q        <= ack_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rd_data_q    <= rd_data_d;
         busy_q       <= busy_d;
         stray_q      <= stray_d;
         spi_wr_req_q <= spi_wr_req_d;
         spi_rd_req_q <= spi_rd_req_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      gnt_idx_d   = gnt_idx_q;
      timer_d     = timer_q;
      lat_wr_d    = lat_wr_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d     = StIssue;
               gnt_idx_d   = pick_idx;
               lat_wr_d    = req_wr[pick_idx];
               lat_addr_d  = req_addr[pick_idx*AD_ADDR_W +: AD_ADDR_W];
               lat_wdata_d = req_wdata[pick_idx*AD_DATA_W +: AD_DATA_W];
            end
         end
         StIssue: begin
            state_d = StWait;
            timer_d = '0;
         end
         StWait: begin
            if (end_hit || tmo_hit) state_d = StDone;
            else                    timer_d = timer_q + 1'b1;
         end
         StDone: begin
            rr_d    = gnt_idx_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output registers are loaded from the transition so they line up with the new state.
   always_comb begin
      ack_d        = '0;
      done_d       = '0;
      err_d        = 1'b0;
      rd_data_d    = rd_data_q;
      spi_wr_req_d = 1'b0;
      spi_rd_req_d = 1'b0;
      busy_d       = (state_d != StIdle);
      stray_d      = stray_ev | (stray_q & ~stray_clr);
      if (state_q == StIdle && state_d == StIssue) begin
         ack_d        = pick_grant;
         spi_wr_req_d = lat_wr_d;
         spi_rd_req_d = ~lat_wr_d;
      end
      if (state_q == StWait && state_d == StDone) begin
         done_d[gnt_idx_q] = 1'b1;
         err_d             = ~end_hit;
         if (!end_hit)      rd_data_d = '0;
         else if (!lat_wr_q) rd_data_d = rd_smp_q;
      end
   end

   assign req_ack     = ack_q;
   assign req_done    = done_q;
   assign req_err     = err_q;
   assign rd_data     = rd_data_q;
   assign busy        = busy_q;
   assign stray_end   = stray_q;
   assign spi.wr_req  = spi_wr_req_q;
   assign spi.rd_req  = spi_rd_req_q;
   assign spi.wr_addr = lat_addr_q;
   assign spi.rd_addr = lat_addr_q;
   assign spi.wr_data = lat_wdata_q;

endmodule

// File: tb/tb_ad9361_spi_arbiter.sv
// Bench for ad9361_spi_arbiter: vector table, directed corner sequences and a
// randomised run against a transaction-level grant model.
module tb_ad9361_spi_arbiter;

   logic        clk;
   logic        rst_n;
   logic        prio_a, clr_a, prio_b, clr_b;
   logic [2:0]  req_a, wr_a, ack_a, done_a, req_b, wr_b, ack_b, done_b;
   logic [29:0] addr_a, addr_b;
   logic [23:0] wdata_a, wdata_b;
   logic        err_a, busy_a, stray_a, err_b, busy_b, stray_b;
   logic [7:0]  rdd_a, rdd_b;

   int n_chk = 0;
   int n_fail = 0;

   ad9361_spi_arbiter_if ifa ();
   ad9361_spi_arbiter_if ifb ();

   ad9361_spi_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(4096), .TMR_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .prio_lock(prio_a), .req(req_a), .req_wr(wr_a),
      .req_addr(addr_a), .req_wdata(wdata_a), .req_ack(ack_a), .req_done(done_a),
      .req_err(err_a), .rd_data(rdd_a), .busy(busy_a), .stray_end(stray_a),
      .stray_clr(clr_a), .spi(ifa)
   );

   ad9361_spi_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(16), .TMR_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .prio_lock(prio_b), .req(req_b), .req_wr(wr_b),
      .req_addr(addr_b), .req_wdata(wdata_b), .req_ack(ack_b), .req_done(done_b),
      .req_err(err_b), .rd_data(rdd_b), .busy(busy_b), .stray_end(stray_b),
      .stray_clr(clr_b), .spi(ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic [2:0] req;
      logic       prio;
      logic       wr;
      logic [9:0] addr;
      logic [7:0] data;
      int         dly;
      int         exp;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int oh2i(input logic [2:0] v);
      int r = -1;
      for (int j = 0; j < 3; j++) if (v[j]) r = j;
      return r;
   endfunction

   function automatic logic [63:0] outs_a();
      return 64'({ack_a, done_a, err_a, rdd_a, busy_a, stray_a, ifa.wr_req, ifa.rd_req,
                  ifa.wr_addr, ifa.wr_data, ifa.rd_addr});
   endfunction

   // Grant model: requester 0 under lock, else the first requester in the
   // rotation that begins just after the last one served.
   function automatic int model_pick(input logic [2:0] r, input logic p, input int rr);
      int order[$];
      if (p && r[0]) return 0;
      for (int off = 1; off <= 3; off++) order.push_back((rr + off) % 3);
      foreach (order[i]) if (r[order[i]]) return order[i];
      return -1;
   endfunction

   task automatic load_a(input int s, input logic w, input logic [9:0] a, input logic [7:0] d);
      wr_a[s] = w;
      addr_a[s*10 +: 10] = a;
      wdata_a[s*8 +: 8] = d;
   endtask

   task automatic load_b(input int s, input logic w, input logic [9:0] a, input logic [7:0] d);
      wr_b[s] = w;
      addr_b[s*10 +: 10] = a;
      wdata_b[s*8 +: 8] = d;
   endtask

   task automatic pulse_a(input logic w, input logic [7:0] d);
      ifa.rd_data = d;
      if (w) ifa.wr_end = 1'b1;
      else   ifa.rd_end = 1'b1;
      tick();
      ifa.wr_end = 1'b0;
      ifa.rd_end = 1'b0;
   endtask

   task automatic pulse_b(input logic w, input logic [7:0] d);
      ifb.rd_data = d;
      if (w) ifb.wr_end = 1'b1;
      else   ifb.rd_end = 1'b1;
      tick();
      ifb.wr_end = 1'b0;
      ifb.rd_end = 1'b0;
   endtask

   task automatic wait_ack_a(output int idx, output int lat);
      idx = -1;
      lat = 0;
      for (int t = 1; t <= 20; t++) begin
         if (idx < 0) begin
            tick();
            if (ack_a != 3'b000) begin
               idx = oh2i(ack_a);
               lat = t;
            end
         end
      end
   endtask

   int         g, lat, mrr, dly;
   logic [2:0] rv, hist;
   logic       pr;
   logic [7:0] rdv;
   logic [2:0] rw;
   logic [9:0] ra[3];
   logic [7:0] rd[3];

   initial begin
      tbl[0]  = '{3'b010, 1'b0, 1'b1, 10'h3F5, 8'h01, 40, 1};
      tbl[1]  = '{3'b100, 1'b0, 1'b0, 10'h037, 8'hA5, 5, 2};
      tbl[2]  = '{3'b111, 1'b0, 1'b1, 10'h155, 8'h3C, 0, 0};
      tbl[3]  = '{3'b111, 1'b0, 1'b0, 10'h2AA, 8'hC3, 2, 1};
      tbl[4]  = '{3'b111, 1'b0, 1'b1, 10'h001, 8'h80, 1, 2};
      tbl[5]  = '{3'b111, 1'b1, 1'b0, 10'h3FF, 8'h7E, 3, 0};
      tbl[6]  = '{3'b111, 1'b1, 1'b1, 10'h200, 8'hFF, 0, 0};
      tbl[7]  = '{3'b110, 1'b1, 1'b0, 10'h0F0, 8'h12, 4, 1};
      tbl[8]  = '{3'b101, 1'b0, 1'b1, 10'h10F, 8'h34, 2, 2};
      tbl[9]  = '{3'b011, 1'b0, 1'b0, 10'h0AB, 8'h56, 1, 0};
      tbl[10] = '{3'b100, 1'b1, 1'b1, 10'h3C3, 8'h9A, 0, 2};

      rst_n = 1'b0;
      prio_a = 1'b0; clr_a = 1'b0; req_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
      prio_b = 1'b0; clr_b = 1'b0; req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0;
      ifa.wr_end = 1'b0; ifa.rd_end = 1'b0; ifa.rd_data = '0;
      ifb.wr_end = 1'b0; ifb.rd_end = 1'b0; ifb.rd_data = '0;
      tick();
      tick();
      chk("reset_outputs", outs_a(), 64'd0);
      rst_n = 1'b1;
      tick();

      // Table: each vector is one full command from request to done.
      foreach (tbl[n]) begin
         for (int s = 0; s < 3; s++) load_a(s, ~tbl[n].wr, ~tbl[n].addr, ~tbl[n].data);
         load_a(tbl[n].exp, tbl[n].wr, tbl[n].addr, tbl[n].data);
         prio_a = tbl[n].prio;
         req_a  = tbl[n].req;
         tick();
         chk($sformatf("tbl%0d_ack", n), 64'(ack_a), 64'(3'b001 << tbl[n].exp));
         chk($sformatf("tbl%0d_spi_req", n), 64'({ifa.wr_req, ifa.rd_req}),
             64'({tbl[n].wr, ~tbl[n].wr}));
         chk($sformatf("tbl%0d_addr", n), 64'({ifa.wr_addr, ifa.rd_addr}),
             64'({tbl[n].addr, tbl[n].addr}));
         if (tbl[n].wr) chk($sformatf("tbl%0d_wdata", n), 64'(ifa.wr_data), 64'(tbl[n].data));
         chk($sformatf("tbl%0d_busy", n), 64'(busy_a), 64'd1);
         req_a = '0;
         repeat (tbl[n].dly) tick();
         pulse_a(tbl[n].wr, tbl[n].data);
         chk($sformatf("tbl%0d_done_early", n), 64'(done_a), 64'd0);
         tick();
         chk($sformatf("tbl%0d_done", n), 64'({done_a, err_a}),
             64'({3'b001 << tbl[n].exp, 1'b0}));
         if (!tbl[n].wr) chk($sformatf("tbl%0d_rd_data", n), 64'(rdd_a), 64'(tbl[n].data));
         tick();
         chk($sformatf("tbl%0d_idle", n), 64'({busy_a, done_a}), 64'd0);
      end

      // Requests held continuously: rotation, then locked priority.
      for (int s = 0; s < 3; s++) load_a(s, 1'b1, 10'(s), 8'(s));
      for (int ph = 0; ph < 2; ph++) begin
         prio_a = ph[0];
         req_a  = 3'b111;
         for (int k = 0; k < 6; k++) begin
            wait_ack_a(g, lat);
            chk($sformatf("hold_p%0d_grant%0d", ph, k), 64'(g), (ph == 0) ? 64'(k % 3) : 64'd0);
            if (k == 5) req_a = '0;
            pulse_a(1'b1, 8'h00);
            tick();
            chk($sformatf("hold_p%0d_done%0d", ph, k), 64'(done_a), 64'(ack_a | (3'b001 << g)));
         end
         tick();
      end

      // Opposite-type end during a write wait.
      prio_a = 1'b0;
      load_a(0, 1'b1, 10'h111, 8'h22);
      req_a = 3'b001;
      wait_ack_a(g, lat);
      chk("stray_ack", 64'(g), 64'd0);
      req_a = '0;
      pulse_a(1'b0, 8'hEE);
      tick();
      chk("stray_set_wait", 64'(stray_a), 64'd1);
      hist = '0;
      repeat (6) begin
         tick();
         hist = hist | done_a;
      end
      chk("stray_no_done", 64'(hist), 64'd0);
      chk("stray_still_busy", 64'(busy_a), 64'd1);
      pulse_a(1'b1, 8'h00);
      tick();
      chk("stray_write_done", 64'({done_a, err_a}), 64'({3'b001, 1'b0}));
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("stray_clr", 64'(stray_a), 64'd0);
      pulse_a(1'b1, 8'h00);
      tick();
      chk("stray_set_idle", 64'(stray_a), 64'd1);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("stray_clr2", 64'(stray_a), 64'd0);
      ifa.wr_end = 1'b1;
      tick();
      ifa.wr_end = 1'b0;
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("stray_set_beats_clr", 64'(stray_a), 64'd1);

      // Reset in the middle of a read wait.
      load_a(1, 1'b0, 10'h2C5, 8'h00);
      req_a = 3'b010;
      wait_ack_a(g, lat);
      chk("rst_ack", 64'(g), 64'd1);
      req_a = '0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wait_outputs", outs_a(), 64'd0);
      tick();
      rst_n = 1'b1;
      pulse_a(1'b0, 8'h77);
      hist = '0;
      repeat (8) begin
         tick();
         hist = hist | done_a;
      end
      chk("rst_no_done", 64'(hist), 64'd0);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;

      // Randomised commands against the grant model; pointer restarts at 2 after reset.
      mrr = 2;
      for (int it = 0; it < 40; it++) begin
         rv = 3'($urandom_range(7, 1));
         pr = 1'($urandom_range(1, 0));
         for (int s = 0; s < 3; s++) begin
            rw[s] = 1'($urandom_range(1, 0));
            ra[s] = 10'($urandom);
            rd[s] = 8'($urandom);
            load_a(s, rw[s], ra[s], rd[s]);
         end
         prio_a = pr;
         req_a  = rv;
         g = model_pick(rv, pr, mrr);
         wait_ack_a(lat, dly);
         chk($sformatf("rnd%0d_grant", it), 64'(lat), 64'(g));
         chk($sformatf("rnd%0d_ack_lat", it), 64'(dly), 64'd1);
         req_a = '0;
         chk($sformatf("rnd%0d_cmd", it), 64'({ifa.wr_req, ifa.rd_req, ifa.wr_addr}),
             64'({rw[g], ~rw[g], ra[g]}));
         if (rw[g]) chk($sformatf("rnd%0d_wdata", it), 64'(ifa.wr_data), 64'(rd[g]));
         repeat ($urandom_range(6, 0)) tick();
         rdv = 8'($urandom);
         pulse_a(rw[g], rdv);
         tick();
         chk($sformatf("rnd%0d_done", it), 64'({done_a, err_a}), 64'({3'b001 << g, 1'b0}));
         if (!rw[g]) chk($sformatf("rnd%0d_rd_data", it), 64'(rdd_a), 64'(rdv));
         mrr = g;
         tick();
      end

      // Timeout instance (16 cycles): write with no end.
      load_b(1, 1'b1, 10'h3F5, 8'h01);
      req_b = 3'b010;
      tick();
      chk("tmo_ack", 64'(ack_b), 64'(3'b010));
      req_b = '0;
      hist = '0;
      repeat (16) begin
         tick();
         hist = hist | done_b;
      end
      chk("tmo_not_early", 64'(hist), 64'd0);
      tick();
      chk("tmo_done_err", 64'({done_b, err_b, rdd_b}), 64'({3'b010, 1'b1, 8'h00}));
      tick();

      load_b(2, 1'b0, 10'h037, 8'h00);
      req_b = 3'b100;
      tick();
      chk("tmo_next_ack", 64'(ack_b), 64'(3'b100));
      req_b = '0;
      repeat (2) tick();
      pulse_b(1'b0, 8'h5A);
      tick();
      chk("tmo_next_done", 64'({done_b, err_b, rdd_b}), 64'({3'b100, 1'b0, 8'h5A}));
      tick();

      // End arriving in the last allowed wait cycle beats the timeout.
      load_b(0, 1'b0, 10'h0C0, 8'h00);
      req_b = 3'b001;
      tick();
      chk("tmo_edge_ack", 64'(ack_b), 64'(3'b001));
      req_b = '0;
      repeat (15) tick();
      pulse_b(1'b0, 8'hC7);
      tick();
      chk("tmo_edge_done", 64'({done_b, err_b, rdd_b}), 64'({3'b001, 1'b0, 8'hC7}));
      tick();

      load_b(1, 1'b0, 10'h155, 8'h00);
      req_b = 3'b010;
      tick();
      chk("tmo_rd_ack", 64'(ack_b), 64'(3'b010));
      req_b = '0;
      repeat (17) tick();
      chk("tmo_rd_done", 64'({done_b, err_b, rdd_b}), 64'({3'b010, 1'b1, 8'h00}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
